fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the pipelined CPU: owns the PC, drives a 1-cycle-latency synchronous
//   instruction memory, and fills the IF/ID pipeline register consumed by the decode stage.
//   Starts fetching at entryPoint on INT, follows taken branch/jump redirects from execute,
//   and holds the IF/ID contents under decode stall without losing an in-flight instruction.
// PARAMETERS
//   XLEN      32            datapath / address width
//   RESET_PC  32'h00000000  PC value loaded by reset
// PORTS
//   clk          in   1     clock; all state updates on rising edge
//   rst_n        in   1     synchronous reset, active low; highest priority
//   INT          in   1     load entryPoint into PC, flush pipe, start fetching
//   entryPoint   in   XLEN  start address used with INT
//   redirect     in   1     taken branch/jump from execute
//   redirect_pc  in   XLEN  redirect target
//   stall        in   1     decode cannot accept a new IF/ID word this cycle
//   imem_req     out  1     read request to instruction memory (combinational)
//   imem_addr    out  XLEN  read address (= PC), bits[1:0] always 0
//   imem_rdata   in   32    instruction for the request issued one cycle earlier
//   ins          out  32    IF/ID instruction
//   pc_out       out  XLEN  IF/ID PC of ins
//   pcp4         out  XLEN  IF/ID pc_out+4
//   valid        out  1     IF/ID holds a real instruction
// BEHAVIOUR
//   Priority per edge: rst_n=0 > INT > redirect > stall > normal advance.
//   Reset: pc=RESET_PC, state=IDLE, inflight=0, hold_v=0, ins=0, pc_out=0, pcp4=0, valid=0; imem_req=0.
//   States: IDLE (no fetch), RUN (fetching), HOLD (stalled with a captured response).
//   IDLE: imem_req=0; INT -> pc<=entryPoint, RUN. redirect/stall ignored.
//   RUN: imem_req=!stall, imem_addr=pc. Request accepted on an edge -> pc<=pc+4, inflight<=1.
//     Else inflight<=0.
//   Response (inflight=1): stall=0 -> IF/ID<={imem_rdata, fetch_pc, fetch_pc+4}, valid<=1.
//     stall=1 -> hold<={imem_rdata, fetch_pc}, hold_v<=1, state HOLD; IF/ID unchanged.
//   RUN, no response, stall=0: valid<=0 (bubble). stall=1: IF/ID unchanged.
//   fetch_pc: registered address of the in-flight request.
//   HOLD: imem_req=0. stall=1 -> unchanged. stall=0 -> IF/ID<=hold, valid<=1, hold_v<=0, RUN.
//     The next request issues on the cycle after leaving HOLD.
//   redirect (RUN/HOLD): pc<=redirect_pc & ~3, inflight<=0 (response next cycle dropped),
//     hold_v<=0, valid<=0, state RUN; applies even when stall=1.
//   INT (any state): same as redirect with entryPoint & ~3; INT wins over a simultaneous redirect.
//   Latency: INT at edge E0 -> first request during cycle after E0 -> valid=1 with
//     ins=mem[entryPoint] after E2. Steady state 1 instruction/cycle.
//   Arithmetic: all PC adds modulo 2^XLEN; 32'hFFFFFFFC+4 wraps to 0, no flag.
//   rst_n=0 mid-operation discards inflight and hold; the response arriving after reset is ignored.
//   stall while valid=0 is legal; IF/ID stays invalid.
// TESTING
//   1 Reset then INT with entryPoint=32'h28, mem[28..2C]=A,B -> valid=0 until E2;
//     then ins=A pc_out=28 pcp4=2C; next cycle ins=B pc_out=2C.
//   2 Stall 3 cycles while 32'h30 is in flight -> ins frozen at 2C entry, HOLD captures mem[30].
//     Release -> ins=mem[30], no skip or duplicate.
//   3 redirect to 32'h80 while 34 is in flight -> mem[34] never valid. One bubble, then ins=mem[80].
//     redirect_pc=32'h83 -> fetch from 80.
//   4 INT and redirect same edge (EP=40, target=90) -> fetching resumes at 40.
//     redirect with stall=1 -> valid=0 next cycle.
//   5 PC=32'hFFFFFFFC -> following fetch address 0, pcp4 of FFFFFFFC entry = 0.
//   6 rst_n low one cycle during HOLD -> all outputs return to reset values, imem_req=0 until INT.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the PC, issues reads to a synchronous
//   instruction memory with one cycle of read latency, and fills the IF/ID
//   register consumed by decode. A decode stall that arrives while a read is
//   in flight parks the returning word in a one-entry hold buffer so it is
//   neither lost nor duplicated.
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst_n        in   synchronous reset, active low, highest priority
//   INT          in   load entryPoint into PC, flush, start fetching
//   entryPoint   in   start address used with INT
//   redirect     in   taken branch/jump from execute
//   redirect_pc  in   redirect target
//   stall        in   decode cannot accept a new IF/ID word this cycle
//   imem_req     out  read request (combinational from state and stall)
//   imem_addr    out  read address (the PC, word aligned)
//   imem_rdata   in   data for the request issued one cycle earlier
//   ins          out  IF/ID instruction
//   pc_out       out  IF/ID PC of ins
//   pcp4         out  IF/ID pc_out + 4
//   valid        out  IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = {XLEN{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             INT,
  input  logic [XLEN-1:0]  entryPoint,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             stall,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ins,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pcp4,
  output logic             valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] C_FOUR       = XLEN'(4);
  localparam logic [XLEN-1:0] C_ALIGN_MASK = ~(XLEN'(3));

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic              r_inflight;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [31:0]       r_hold_ins;
  logic [XLEN-1:0]   r_hold_pc;
  logic              r_hold_v;
  logic [31:0]       r_ins;
  logic [XLEN-1:0]   r_pc_out;
  logic [XLEN-1:0]   r_pcp4;
  logic              r_valid;

  state_t            w_state_nxt;
  logic [XLEN-1:0]   w_pc_nxt;
  logic              w_inflight_nxt;
  logic [XLEN-1:0]   w_fetch_pc_nxt;
  logic [31:0]       w_hold_ins_nxt;
  logic [XLEN-1:0]   w_hold_pc_nxt;
  logic              w_hold_v_nxt;
  logic [31:0]       w_ins_nxt;
  logic [XLEN-1:0]   w_pc_out_nxt;
  logic [XLEN-1:0]   w_pcp4_nxt;
  logic              w_valid_nxt;
  logic              w_req;

  // State register: synchronous active-low reset, otherwise take next-state values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_fetch_pc <= {XLEN{1'b0}};
      r_hold_ins <= 32'd0;
      r_hold_pc  <= {XLEN{1'b0}};
      r_hold_v   <= 1'b0;
      r_ins      <= 32'd0;
      r_pc_out   <= {XLEN{1'b0}};
      r_pcp4     <= {XLEN{1'b0}};
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inflight <= w_inflight_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_hold_ins <= w_hold_ins_nxt;
      r_hold_pc  <= w_hold_pc_nxt;
      r_hold_v   <= w_hold_v_nxt;
      r_ins      <= w_ins_nxt;
      r_pc_out   <= w_pc_out_nxt;
      r_pcp4     <= w_pcp4_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  // Next-state and request logic: INT > redirect > stall > normal advance.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_inflight_nxt = 1'b0;
    w_fetch_pc_nxt = r_fetch_pc;
    w_hold_ins_nxt = r_hold_ins;
    w_hold_pc_nxt  = r_hold_pc;
    w_hold_v_nxt   = r_hold_v;
    w_ins_nxt      = r_ins;
    w_pc_out_nxt   = r_pc_out;
    w_pcp4_nxt     = r_pcp4;
    w_valid_nxt    = r_valid;
    w_req          = 1'b0;

    // Only RUN issues reads; a stalled decode suppresses the request so the
    // stage never has more than one word that decode has not accepted.
    case (r_state)
      S_IDLE:  w_req = 1'b0;
      S_RUN:   w_req = ~stall;
      S_HOLD:  w_req = 1'b0;
      default: w_req = 1'b0;
    endcase

    if (INT) begin
      // Flush everything; the in-flight response is dropped via inflight=0.
      w_pc_nxt     = entryPoint & C_ALIGN_MASK;
      w_hold_v_nxt = 1'b0;
      w_valid_nxt  = 1'b0;
      w_state_nxt  = S_RUN;
    end else if (redirect && (r_state != S_IDLE)) begin
      w_pc_nxt     = redirect_pc & C_ALIGN_MASK;
      w_hold_v_nxt = 1'b0;
      w_valid_nxt  = 1'b0;
      w_state_nxt  = S_RUN;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_RUN: begin
          if (w_req) begin
            w_pc_nxt       = r_pc + C_FOUR;
            w_inflight_nxt = 1'b1;
            w_fetch_pc_nxt = r_pc;
          end else begin
            w_inflight_nxt = 1'b0;
          end
          if (r_inflight) begin
            if (!stall) begin
              w_ins_nxt    = imem_rdata;
              w_pc_out_nxt = r_fetch_pc;
              w_pcp4_nxt   = r_fetch_pc + C_FOUR;
              w_valid_nxt  = 1'b1;
            end else begin
              // Decode is busy: park the returning word instead of losing it.
              w_hold_ins_nxt = imem_rdata;
              w_hold_pc_nxt  = r_fetch_pc;
              w_hold_v_nxt   = 1'b1;
              w_state_nxt    = S_HOLD;
            end
          end else begin
            if (!stall) begin
              w_valid_nxt = 1'b0;
            end else begin
              w_valid_nxt = r_valid;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_ins_nxt    = r_hold_ins;
            w_pc_out_nxt = r_hold_pc;
            w_pcp4_nxt   = r_hold_pc + C_FOUR;
            w_valid_nxt  = 1'b1;
            w_hold_v_nxt = 1'b0;
            w_state_nxt  = S_RUN;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign ins       = r_ins;
  assign pc_out    = r_pc_out;
  assign pcp4      = r_pcp4;
  assign valid     = r_valid;

endmodule
